if_pc_gen: RTL and testbench

- Fetch (IF) stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID register.
- Holds the program counter and computes next-PC from the 4-bit PCSrc code decoded in ID, plus forwarded ID-stage operands.
- Also applies CP0 exception/eret redirection and stall hold.
- Produces the fetch PC, the fetched instruction (nulled on bad address), and the delay-slot flag BD, all of which the IF/ID register latches.

---
 rtl/if_pc_gen.sv | 133 +++++++++++++
 tb/tb_if_pc_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/if_pc_gen.sv
// Fetch stage PC generator: holds the fetch PC, computes next-PC from the ID-stage select code, applies exception/eret redirection.
// Latency: npc appears on pc one clock later; instr/bd/adel are combinational from pc, im_instr and the ID-stage inputs.
// Backpressure: stall holds pc (exc_req overrides stall); there is no internal buffering.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   stall             hazard stall, holds pc
//   exc_req           CP0 exception/interrupt taken this cycle
//   pcsrc[3:0]        next-PC select decoded in ID
//   id_instr, id_pc   instruction in ID and its PC (imm16 / index26 source)
//   rs_val, rt_val    forwarded GPR operands for branch compare / jr
//   epc               forwarded CP0 EPC for eret
//   im_instr          instruction memory read data at pc
//   pc                registered fetch PC
//   instr             fetched instruction (zeroed on bad address or eret squash)
//   bd                fetched instruction sits in a branch/jump delay slot
//   adel              fetch address error
//   fetch_cnt         (only when FETCH_CNT_EN is defined) accepted-fetch counter
//
// Optional feature macro: FETCH_CNT_EN
module if_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exc_req,
  input  logic [3:0]  pcsrc,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_pc,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [31:0] epc,
  input  logic [31:0] im_instr,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        bd,
`ifdef FETCH_CNT_EN
  output logic [31:0] fetch_cnt,
`endif
  output logic        adel
);

  localparam logic [3:0] SRC_SEQ  = 4'd0;
  localparam logic [3:0] SRC_BEQ  = 4'd1;
  localparam logic [3:0] SRC_J    = 4'd2;
  localparam logic [3:0] SRC_JR   = 4'd3;
  localparam logic [3:0] SRC_BNE  = 4'd4;
  localparam logic [3:0] SRC_BLEZ = 4'd5;
  localparam logic [3:0] SRC_BGTZ = 4'd6;
  localparam logic [3:0] SRC_BLTZ = 4'd7;
  localparam logic [3:0] SRC_BGEZ = 4'd8;
  localparam logic [3:0] SRC_ERET = 4'd9;

  logic [31:0] seq_pc;
  logic [31:0] link_pc;
  logic [31:0] imm_off;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] npc;
  logic        rs_zero;
  logic        rs_neg;
  logic        is_xfer;
  logic        addr_bad;
  logic        squash;
  logic        unused_opc;

  // Opcode field is decoded in ID; only imm16/index26 matter here.
  assign unused_opc = ^id_instr[31:26];

  assign seq_pc  = pc + 32'd4;
  assign link_pc = id_pc + 32'd4;
  assign imm_off = {{14{id_instr[15]}}, id_instr[15:0], 2'b00};
  assign br_tgt  = link_pc + imm_off;
  assign j_tgt   = {link_pc[31:28], id_instr[25:0], 2'b00};
  assign rs_zero = (rs_val == 32'd0);
  assign rs_neg  = rs_val[31];

  // Untaken branches fall through to pc+4 so the delay slot is still fetched.
  always_comb begin
    npc = seq_pc;
    case (pcsrc)
      SRC_SEQ:  npc = seq_pc;
      SRC_BEQ:  npc = (rs_val == rt_val) ? br_tgt : seq_pc;
      SRC_J:    npc = j_tgt;
      SRC_JR:   npc = rs_val;
      SRC_BNE:  npc = (rs_val != rt_val) ? br_tgt : seq_pc;
      SRC_BLEZ: npc = (rs_neg || rs_zero) ? br_tgt : seq_pc;
      SRC_BGTZ: npc = (!rs_neg && !rs_zero) ? br_tgt : seq_pc;
      SRC_BLTZ: npc = rs_neg ? br_tgt : seq_pc;
      SRC_BGEZ: npc = !rs_neg ? br_tgt : seq_pc;
      SRC_ERET: npc = epc;
      default:  npc = seq_pc;
    endcase
  end

  // Exception redirect ignores stall; a stalled redirect is simply
  // re-evaluated next cycle from the held ID inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      squash <= 1'b0;
    end else begin
      squash <= (pcsrc == SRC_ERET) && !stall && !exc_req;
      if (exc_req)
        pc <= EXC_VEC;
      else if (!stall)
        pc <= npc;
    end
  end

`ifdef FETCH_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      fetch_cnt <= 32'd0;
    else if (!stall && !exc_req && !squash)
      fetch_cnt <= fetch_cnt + 32'd1;
  end
`endif

  assign is_xfer  = (pcsrc >= SRC_BEQ) && (pcsrc <= SRC_BGEZ);
  assign addr_bad = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LIMIT);

  // The instruction fetched right after eret is squashed to a nop and
  // carries no exception or delay-slot attribute.
  assign adel  = addr_bad && !squash;
  assign bd    = is_xfer && !exc_req && !reset && !squash;
  assign instr = (addr_bad || squash) ? 32'h0 : im_instr;

endmodule

// File: tb/tb_if_pc_gen.sv
module tb_if_pc_gen;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        exc_req;
  logic [3:0]  pcsrc;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] epc;
  logic [31:0] im_instr;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        bd;
  logic        adel;
`ifdef FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  if_pc_gen dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .exc_req  (exc_req),
    .pcsrc    (pcsrc),
    .id_instr (id_instr),
    .id_pc    (id_pc),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .epc      (epc),
    .im_instr (im_instr),
    .pc       (pc),
    .instr    (instr),
    .bd       (bd),
`ifdef FETCH_CNT_EN
    .fetch_cnt(fetch_cnt),
`endif
    .adel     (adel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        bd;
    logic        adel;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   vidx   = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL v%0d %s: got %h expected %h", idx, name, act, req);
    end
  endtask

  // Drive one cycle of stimulus just after the edge and queue the outputs
  // expected during that cycle (pc is the value latched at this edge).
  task automatic vec(input logic rst, input logic stl, input logic exc, input logic [3:0] src,
                     input logic [31:0] iins, input logic [31:0] ipc, input logic [31:0] rs,
                     input logic [31:0] rt, input logic [31:0] ep,
                     input logic [31:0] e_pc, input logic e_bd, input logic e_adel,
                     input logic e_null, input logic [31:0] e_cnt);
    exp_t e;
    @(posedge clk);
    #1;
    reset    = rst;
    stall    = stl;
    exc_req  = exc;
    pcsrc    = src;
    id_instr = iins;
    id_pc    = ipc;
    rs_val   = rs;
    rt_val   = rt;
    epc      = ep;
    im_instr = 32'h1234_0000 | vidx;
    e.idx    = vidx;
    e.pc     = e_pc;
    e.instr  = e_null ? 32'h0 : (32'h1234_0000 | vidx);
    e.bd     = e_bd;
    e.adel   = e_adel;
    e.cnt    = e_cnt;
    q.push_back(e);
    vidx++;
  endtask

  // Monitor: compares whatever the DUT presents mid-cycle against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pc",    e.idx, pc,    e.pc);
        chk("instr", e.idx, instr, e.instr);
        chk("bd",    e.idx, {31'd0, bd},   {31'd0, e.bd});
        chk("adel",  e.idx, {31'd0, adel}, {31'd0, e.adel});
`ifdef FETCH_CNT_EN
        chk("fetch_cnt", e.idx, fetch_cnt, e.cnt);
`endif
      end
    end
  end

  localparam logic [31:0] I_BM4 = 32'h1000_FFFC;  // imm16 = -4
  localparam logic [31:0] I_J   = 32'h0800_0D00;  // index26 = 0xD00
  localparam logic [31:0] I_P3  = 32'h1000_0003;  // imm16 = 3
  localparam logic [31:0] I_P4  = 32'h1000_0004;  // imm16 = 4
  localparam logic [31:0] I_M1  = 32'h1000_FFFF;  // imm16 = -1

  initial begin
    int waited;
    reset = 1'b1; stall = 1'b0; exc_req = 1'b0; pcsrc = 4'd0;
    id_instr = '0; id_pc = '0; rs_val = '0; rt_val = '0; epc = '0; im_instr = '0;

    //   rst  stl  exc  src    id_instr id_pc         rs            rt     epc            exp_pc        bd   adel null cnt
    vec(1'b1,1'b0,1'b0,4'd0,  32'h0,   32'h0,        32'h0,        32'h0, 32'h0,        32'h3000,     1'b0,1'b0,1'b0,32'd0);
    vec(1'b0,1'b0,1'b0,4'd0,  32'h0,   32'h0,        32'h0,        32'h0, 32'h0,        32'h3000,     1'b0,1'b0,1'b0,32'd0);
    vec(1'b0,1'b0,1'b0,4'd0,  32'h0,   32'h0,        32'h0,        32'h0, 32'h0,        32'h3004,     1'b0,1'b0,1'b0,32'd1);
    vec(1'b0,1'b0,1'b0,4'd0,  32'h0,   32'h0,        32'h0,        32'h0, 32'h0,        32'h3008,     1'b0,1'b0,1'b0,32'd2);
    // beq taken then not taken
    vec(1'b0,1'b0,1'b0,4'd1,  I_BM4,   32'h3010,     32'd5,        32'd5, 32'h0,        32'h300C,     1'b1,1'b0,1'b0,32'd3);
    vec(1'b0,1'b0,1'b0,4'd1,  I_BM4,   32'h3010,     32'd5,        32'd6, 32'h0,        32'h3004,     1'b1,1'b0,1'b0,32'd4);
    // j, jr to misaligned address
    vec(1'b0,1'b0,1'b0,4'd2,  I_J,     32'h3020,     32'h0,        32'h0, 32'h0,        32'h3008,     1'b1,1'b0,1'b0,32'd5);
    vec(1'b0,1'b0,1'b0,4'd3,  32'h0,   32'h0,        32'h3002,     32'h0, 32'h0,        32'h3400,     1'b1,1'b0,1'b0,32'd6);
    vec(1'b0,1'b0,1'b0,4'd0,  32'h0,   32'h0,        32'h0,        32'h0, 32'h0,        32'h3002,     1'b0,1'b1,1'b1,32'd7);
    vec(1'b0,1'b0,1'b0,4'd3,  32'h0,   32'h0,        32'h3100,     32'h0, 32'h0,        32'h3006,     1'b1,1'b1,1'b1,32'd8);
    // stalled taken bne, then exception during stall
    vec(1'b0,1'b1,1'b0,4'd4,  I_P3,    32'h3200,     32'd1,        32'd2, 32'h0,        32'h3100,     1'b1,1'b0,1'b0,32'd9);
    vec(1'b0,1'b1,1'b0,4'd4,  I_P3,    32'h3200,     32'd1,        32'd2, 32'h0,        32'h3100,     1'b1,1'b0,1'b0,32'd9);
    vec(1'b0,1'b1,1'b0,4'd4,  I_P3,    32'h3200,     32'd1,        32'd2, 32'h0,        32'h3100,     1'b1,1'b0,1'b0,32'd9);
    vec(1'b0,1'b0,1'b0,4'd4,  I_P3,    32'h3200,     32'd1,        32'd2, 32'h0,        32'h3100,     1'b1,1'b0,1'b0,32'd9);
    vec(1'b0,1'b1,1'b1,4'd1,  I_BM4,   32'h3010,     32'd5,        32'd5, 32'h0,        32'h3210,     1'b0,1'b0,1'b0,32'd10);
    vec(1'b0,1'b0,1'b0,4'd0,  32'h0,   32'h0,        32'h0,        32'h0, 32'h0,        32'h4180,     1'b0,1'b0,1'b0,32'd10);
    // eret, squash cycle, then eret colliding with exception
    vec(1'b0,1'b0,1'b0,4'd9,  32'h0,   32'h0,        32'h0,        32'h0, 32'h3050,     32'h4184,     1'b0,1'b0,1'b0,32'd11);
    vec(1'b0,1'b0,1'b0,4'd0,  32'h0,   32'h0,        32'h0,        32'h0, 32'h0,        32'h3050,     1'b0,1'b0,1'b1,32'd12);
    vec(1'b0,1'b0,1'b1,4'd9,  32'h0,   32'h0,        32'h0,        32'h0, 32'h3060,     32'h3054,     1'b0,1'b0,1'b0,32'd12);
    vec(1'b0,1'b0,1'b0,4'd0,  32'h0,   32'h0,        32'h0,        32'h0, 32'h0,        32'h4180,     1'b0,1'b0,1'b0,32'd12);
    // blez taken, bgtz not taken, bltz taken, bgez not taken
    vec(1'b0,1'b0,1'b0,4'd5,  I_P4,    32'h3300,     32'hFFFF_FFFF,32'h0, 32'h0,        32'h4184,     1'b1,1'b0,1'b0,32'd13);
    vec(1'b0,1'b0,1'b0,4'd6,  I_P4,    32'h3300,     32'h0,        32'h0, 32'h0,        32'h3314,     1'b1,1'b0,1'b0,32'd14);
    vec(1'b0,1'b0,1'b0,4'd7,  I_M1,    32'h3300,     32'h8000_0000,32'h0, 32'h0,        32'h3318,     1'b1,1'b0,1'b0,32'd15);
    vec(1'b0,1'b0,1'b0,4'd8,  I_M1,    32'h3300,     32'h8000_0000,32'h0, 32'h0,        32'h3300,     1'b1,1'b0,1'b0,32'd16);
    // range boundaries
    vec(1'b0,1'b0,1'b0,4'd3,  32'h0,   32'h0,        32'h7000,     32'h0, 32'h0,        32'h3304,     1'b1,1'b0,1'b0,32'd17);
    vec(1'b0,1'b0,1'b0,4'd0,  32'h0,   32'h0,        32'h0,        32'h0, 32'h0,        32'h7000,     1'b0,1'b1,1'b1,32'd18);
    vec(1'b0,1'b0,1'b0,4'd3,  32'h0,   32'h0,        32'h2FFC,     32'h0, 32'h0,        32'h7004,     1'b1,1'b1,1'b1,32'd19);
    vec(1'b0,1'b0,1'b0,4'd3,  32'h0,   32'h0,        32'h6FFC,     32'h0, 32'h0,        32'h2FFC,     1'b1,1'b1,1'b1,32'd20);
    vec(1'b0,1'b0,1'b0,4'd1,  I_BM4,   32'h3010,     32'd5,        32'd5, 32'h0,        32'h6FFC,     1'b1,1'b0,1'b0,32'd21);
    // reset during a taken branch
    vec(1'b1,1'b0,1'b0,4'd1,  I_BM4,   32'h3010,     32'd5,        32'd5, 32'h0,        32'h3004,     1'b0,1'b0,1'b0,32'd22);
    vec(1'b0,1'b0,1'b0,4'd0,  32'h0,   32'h0,        32'h0,        32'h0, 32'h0,        32'h3000,     1'b0,1'b0,1'b0,32'd0);
    vec(1'b0,1'b0,1'b0,4'd12, 32'h0,   32'h0,        32'h0,        32'h0, 32'h0,        32'h3004,     1'b0,1'b0,1'b0,32'd1);
    vec(1'b0,1'b0,1'b0,4'd0,  32'h0,   32'h0,        32'h0,        32'h0, 32'h0,        32'h3008,     1'b0,1'b0,1'b0,32'd2);

    waited = 0;
    while (q.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
